// File: rtl/uart_rx_capture.sv
// uart_rx_capture
//   Receives the 8N1 serial stream from the core's Tx pin and buffers the
//   decoded bytes in a small first-word-fall-through FIFO. The line is
//   oversampled OVERSAMPLE times per bit. A start bit must still be low at
//   mid-bit to be accepted. A low stop bit raises frame_err. A byte that
//   completes while the FIFO is full raises overrun.
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous reset, active-high
//   rx         serial line, idle high, asynchronous to clk
//   rd_en      pop request, ignored while empty
//   rd_data    head-of-FIFO byte
//   empty/full FIFO occupancy flags
//   frame_err  sticky, stop bit sampled low
//   overrun    sticky, byte dropped because the FIFO was full
//   clr_err    clears both sticky flags (a same-cycle new error wins)
module uart_rx_capture #(
   parameter int SYS_CLK_FREQ = 100_000_000,
   parameter int BAUD_RATE    = 115200,
   parameter int OVERSAMPLE   = 16,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       empty,
   output logic       full,
   output logic       frame_err,
   output logic       overrun,
   input  logic       clr_err
);

   localparam int DIV = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int AW  = $clog2(FIFO_DEPTH);

   localparam logic [TW-1:0] TMAX   = TW'(DIV - 1);
   localparam logic [SW-1:0] SC_MID = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SC_END = SW'(OVERSAMPLE - 1);

   if (DIV < 1) begin : g_bad_div
      $error("uart_rx_capture: SYS_CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 1");
   end
   if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
      $error("uart_rx_capture: OVERSAMPLE must be even and >= 4");
   end
   if ((FIFO_DEPTH < 2) || ((1 << AW) != FIFO_DEPTH)) begin : g_bad_depth
      $error("uart_rx_capture: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t        state;
   logic          rx_m, rx_s;
   logic [TW-1:0] tcnt;
   logic          tick;
   logic [SW-1:0] sc;
   logic [2:0]    bitn;
   logic [7:0]    shreg;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wptr, rptr;
   logic          stop_smp, push, pop, wr_ok, fe_set, ov_set;

   // Two-flop synchroniser; idles high so reset does not fake a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // Free-running oversample tick. It is not restarted by the FSM, so the
   // start-edge phase error is at most one tick.
   always_ff @(posedge clk) begin
      if (rst)               tcnt <= '0;
      else if (tcnt == TMAX) tcnt <= '0;
      else                   tcnt <= tcnt + 1'b1;
   end
   assign tick = (tcnt == TMAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         sc    <= '0;
         bitn  <= '0;
         shreg <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  state <= S_START;
                  sc    <= '0;
               end
            end
            // Half a bit after the falling edge: still low means a real start bit.
            S_START: begin
               if (tick) begin
                  if (sc == SC_MID) begin
                     sc    <= '0;
                     bitn  <= '0;
                     state <= rx_s ? S_IDLE : S_DATA;
                  end else begin
                     sc <= sc + 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (tick) begin
                  if (sc == SC_END) begin
                     sc    <= '0;
                     shreg <= {rx_s, shreg[7:1]};
                     bitn  <= bitn + 1'b1;
                     if (bitn == 3'd7) state <= S_STOP;
                  end else begin
                     sc <= sc + 1'b1;
                  end
               end
            end
            S_STOP: begin
               if (tick) begin
                  if (sc == SC_END) begin
                     sc    <= '0;
                     state <= rx_s ? S_IDLE : S_BREAK;
                  end else begin
                     sc <= sc + 1'b1;
                  end
               end
            end
            // A low stop bit may be a break condition; wait for the line to recover.
            S_BREAK: begin
               if (rx_s) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign stop_smp = (state == S_STOP) && tick && (sc == SC_END);
   assign push     = stop_smp && rx_s;
   assign fe_set   = stop_smp && !rx_s;

   assign pop   = rd_en && !empty;
   // When full, a simultaneous pop frees the slot the push is about to use.
   assign wr_ok  = push && (!full || pop);
   assign ov_set = push && full && !pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rd_data = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_ok) begin
            mem[wptr[AW-1:0]] <= shreg;
            wptr              <= wptr + 1'b1;
         end
         if (pop) rptr <= rptr + 1'b1;
      end
   end

   // Sticky flags; a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (fe_set)       frame_err <= 1'b1;
         else if (clr_err) frame_err <= 1'b0;
         if (ov_set)       overrun   <= 1'b1;
         else if (clr_err) overrun   <= 1'b0;
      end
   end

endmodule
